// File: rtl/rv32i_types.sv
// Shared ROB types: entry status encoding, the lightweight ROB entry record
// and the default ROB geometry.
`default_nettype none

package rv32i_types;

  localparam int ROB_DEPTH    = 32;
  localparam int ROB_NUM_WB   = 4;
  localparam int ROB_COMMIT_W = 2;

  typedef enum logic [1:0] {
    rob_empty = 2'd0,
    rob_wait  = 2'd1,
    rob_done  = 2'd2
  } status_t;

  typedef struct packed {
    status_t     status;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] pc;
    logic [31:0] rd_data;
    logic        br_en;
    logic [31:0] pc_new;
  } rob_lite_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_commit_select.sv
// Retire-slot eligibility: a slot retires only if every older slot retires
// too, and nothing younger than a redirecting slot may retire.
`default_nettype none

module rob_commit_select
  import rv32i_types::*;
#(
  parameter int COMMIT_W = ROB_COMMIT_W
) (
  input  logic [COMMIT_W-1:0] ready_i,
  input  logic [COMMIT_W-1:0] br_en_i,
  output logic [COMMIT_W-1:0] commit_valid_o,
  output logic [COMMIT_W-1:0] flush_sel_o,
  output logic                flush_o
);

  logic [COMMIT_W-1:0] run;

  assign run[0] = 1'b1;

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_chain
    assign commit_valid_o[k] = run[k] & ready_i[k];
    if (k < COMMIT_W - 1) begin : g_next
      assign run[k+1] = commit_valid_o[k] & ~br_en_i[k];
    end
  end

  // At most one bit can be set: the chain is cut right after the first branch.
  assign flush_sel_o = commit_valid_o & br_en_i;
  assign flush_o     = |flush_sel_o;

endmodule

`default_nettype wire

// File: rtl/rob_multi.sv
// Circular reorder buffer with multi-port out-of-order writeback, up to
// COMMIT_W in-order retirements per cycle and branch-redirect flush.
`default_nettype none

module rob_multi
  import rv32i_types::*;
#(
  parameter  int DEPTH    = ROB_DEPTH,
  parameter  int NUM_WB   = ROB_NUM_WB,
  parameter  int COMMIT_W = ROB_COMMIT_W,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [4:0]             dispatch_rd_addr,
  input  logic                   dispatch_regf_we,
  input  logic [31:0]            dispatch_pc,
  output logic [IDX_W-1:0]       dispatch_idx,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx,
  input  logic [NUM_WB*32-1:0]   wb_data,
  input  logic [NUM_WB-1:0]      wb_br_en,
  input  logic [NUM_WB*32-1:0]   wb_pc_new,
  output logic [COMMIT_W-1:0]    commit_valid,
  output logic [COMMIT_W*IDX_W-1:0] commit_idx,
  output logic [COMMIT_W*5-1:0]  commit_rd_addr,
  output logic [COMMIT_W*32-1:0] commit_data,
  output logic [COMMIT_W-1:0]    commit_regf_we,
  output logic                   flush,
  output logic [31:0]            flush_pc,
  output logic [IDX_W:0]         count,
  output logic                   empty
);

  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  rob_lite_entry_t     entry_q [DEPTH];
  rob_lite_entry_t     entry_d [DEPTH];
  logic [IDX_W:0]      head_q, head_d;
  logic [IDX_W:0]      tail_q, tail_d;
  logic                full;
  logic [COMMIT_W-1:0] slot_ready;
  logic [COMMIT_W-1:0] slot_br;
  logic [COMMIT_W-1:0] flush_sel;
  logic [IDX_W-1:0]    slot_idx [COMMIT_W];
  logic [31:0]         unused_pc;

  // Occupancy comes from registered pointers only, so a retirement this
  // cycle frees its slot for dispatch no earlier than the next cycle.
  assign count          = tail_q - head_q;
  assign empty          = (count == '0);
  assign full           = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                          (head_q[IDX_W] != tail_q[IDX_W]);
  assign dispatch_ready = !full && !flush;
  assign dispatch_idx   = tail_q[IDX_W-1:0];

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
    assign slot_idx[k]   = head_q[IDX_W-1:0] + IDX_W'(k);
    assign slot_ready[k] = (entry_q[slot_idx[k]].status == rob_done) &&
                           (count > (IDX_W+1)'(k));
    assign slot_br[k]    = entry_q[slot_idx[k]].br_en;
    assign commit_idx[k*IDX_W +: IDX_W] = slot_idx[k];
    assign commit_rd_addr[k*5 +: 5]     = entry_q[slot_idx[k]].rd_addr;
    assign commit_data[k*32 +: 32]      = entry_q[slot_idx[k]].rd_data;
    assign commit_regf_we[k]            = entry_q[slot_idx[k]].regf_we;
  end

  rob_commit_select #(
    .COMMIT_W (COMMIT_W)
  ) u_commit_select (
    .ready_i        (slot_ready),
    .br_en_i        (slot_br),
    .commit_valid_o (commit_valid),
    .flush_sel_o    (flush_sel),
    .flush_o        (flush)
  );

  always_comb begin
    flush_pc = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (flush_sel[k]) flush_pc = entry_q[slot_idx[k]].pc_new;
    end
  end

  always_comb begin
    unused_pc = '0;
    for (int i = 0; i < DEPTH; i++) unused_pc = unused_pc ^ entry_q[i].pc;
  end

  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
      head_d = '0;
      tail_d = '0;
    end else begin
      if (dispatch_valid && dispatch_ready) begin
        entry_d[tail_q[IDX_W-1:0]] = '{status:  rob_wait,
                                       rd_addr: dispatch_rd_addr,
                                       regf_we: dispatch_regf_we,
                                       pc:      dispatch_pc,
                                       rd_data: 32'h0,
                                       br_en:   1'b0,
                                       pc_new:  32'h0};
        tail_d = tail_q + PTR_ONE;
      end
      // Ascending port order lets the highest-numbered port win a collision.
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && (entry_q[wb_idx[p*IDX_W +: IDX_W]].status == rob_wait)) begin
          entry_d[wb_idx[p*IDX_W +: IDX_W]].status  = rob_done;
          entry_d[wb_idx[p*IDX_W +: IDX_W]].rd_data = wb_data[p*32 +: 32];
          entry_d[wb_idx[p*IDX_W +: IDX_W]].br_en   = wb_br_en[p];
          entry_d[wb_idx[p*IDX_W +: IDX_W]].pc_new  = wb_pc_new[p*32 +: 32];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid[k]) begin
          entry_d[slot_idx[k]].status = rob_empty;
          head_d = head_d + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: a DEPTH=32/COMMIT_W=2 instance for the
// directed cases and a DEPTH=8/COMMIT_W=4 instance for a scoreboarded stream.
`default_nettype none

module tb_rob_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: DEPTH 32, NUM_WB 4, COMMIT_W 2
  logic        a_dv, a_dr, a_dwe;
  logic [4:0]  a_drd, a_didx;
  logic [31:0] a_dpc;
  logic [3:0]  a_wbv, a_wbbr;
  logic [19:0] a_wbidx;
  logic [127:0] a_wbdata, a_wbpc;
  logic [1:0]  a_cv, a_cwe;
  logic [9:0]  a_cidx, a_crd;
  logic [63:0] a_cdata;
  logic        a_flush, a_empty;
  logic [31:0] a_fpc;
  logic [5:0]  a_cnt;

  // Instance B: DEPTH 8, NUM_WB 4, COMMIT_W 4
  logic        b_dv, b_dr, b_dwe;
  logic [4:0]  b_drd;
  logic [2:0]  b_didx;
  logic [31:0] b_dpc;
  logic [3:0]  b_wbv, b_wbbr;
  logic [11:0] b_wbidx;
  logic [127:0] b_wbdata, b_wbpc;
  logic [3:0]  b_cv, b_cwe;
  logic [11:0] b_cidx;
  logic [19:0] b_crd;
  logic [127:0] b_cdata;
  logic        b_flush, b_empty;
  logic [31:0] b_fpc;
  logic [3:0]  b_cnt;

  rob_multi #(.DEPTH(32), .NUM_WB(4), .COMMIT_W(2)) u_a (
    .clk(clk), .rst(rst),
    .dispatch_valid(a_dv), .dispatch_ready(a_dr), .dispatch_rd_addr(a_drd),
    .dispatch_regf_we(a_dwe), .dispatch_pc(a_dpc), .dispatch_idx(a_didx),
    .wb_valid(a_wbv), .wb_idx(a_wbidx), .wb_data(a_wbdata),
    .wb_br_en(a_wbbr), .wb_pc_new(a_wbpc),
    .commit_valid(a_cv), .commit_idx(a_cidx), .commit_rd_addr(a_crd),
    .commit_data(a_cdata), .commit_regf_we(a_cwe),
    .flush(a_flush), .flush_pc(a_fpc), .count(a_cnt), .empty(a_empty)
  );

  rob_multi #(.DEPTH(8), .NUM_WB(4), .COMMIT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .dispatch_valid(b_dv), .dispatch_ready(b_dr), .dispatch_rd_addr(b_drd),
    .dispatch_regf_we(b_dwe), .dispatch_pc(b_dpc), .dispatch_idx(b_didx),
    .wb_valid(b_wbv), .wb_idx(b_wbidx), .wb_data(b_wbdata),
    .wb_br_en(b_wbbr), .wb_pc_new(b_wbpc),
    .commit_valid(b_cv), .commit_idx(b_cidx), .commit_rd_addr(b_crd),
    .commit_data(b_cdata), .commit_regf_we(b_cwe),
    .flush(b_flush), .flush_pc(b_fpc), .count(b_cnt), .empty(b_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic a_idle();
    a_dv = 0; a_drd = '0; a_dwe = 0; a_dpc = '0;
    a_wbv = '0; a_wbidx = '0; a_wbdata = '0; a_wbbr = '0; a_wbpc = '0;
  endtask

  task automatic b_idle();
    b_dv = 0; b_drd = '0; b_dwe = 0; b_dpc = '0;
    b_wbv = '0; b_wbidx = '0; b_wbdata = '0; b_wbbr = '0; b_wbpc = '0;
  endtask

  task automatic a_wb(input int p, input int idx, input logic [31:0] d,
                      input logic br, input logic [31:0] pcn);
    a_wbv[p] = 1'b1;
    a_wbidx[p*5 +: 5] = 5'(idx);
    a_wbdata[p*32 +: 32] = d;
    a_wbbr[p] = br;
    a_wbpc[p*32 +: 32] = pcn;
  endtask

  task automatic a_disp(input int rd);
    a_dv = 1'b1; a_drd = 5'(rd); a_dwe = 1'b1; a_dpc = 32'h1000 + 32'(rd * 4);
  endtask

  // Advance one clock; inputs return to idle after the edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    a_idle();
  endtask

  typedef struct { int idx; int rd; bit done; } sb_t;
  sb_t         sbq[$];
  int          pend[$];
  logic [31:0] exp_data [8];
  int          ndisp, ncomm, tail_m, wb_idx_v, wb_port, wb_pick, ncom_exp, qs;
  bit          dv, hs, wbd;
  logic [3:0]  cmask;

  initial begin
    rst = 1'b0;
    a_idle();
    b_idle();
    #2;
    chk("rst_count", a_cnt, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_ready", a_dr, 1);
    chk("rst_cv", a_cv, 0);
    chk("rst_flush", a_flush, 0);
    chk("rst_fpc", a_fpc, 0);
    chk("rst_didx", a_didx, 0);
    @(negedge clk);
    rst = 1'b1;

    // Out-of-order writeback, in-order retire
    for (int i = 0; i < 3; i++) begin
      a_disp(i + 1);
      #1;
      chk("t1_didx", a_didx, 5'(i));
      chk("t1_ready", a_dr, 1);
      cyc();
    end
    #1;
    chk("t1_count", a_cnt, 3);
    chk("t1_cv_none", a_cv, 0);
    a_wb(0, 2, 32'hD2, 0, 0);
    cyc();
    #1;
    chk("t1_cv_after_wb2", a_cv, 0);
    a_wb(1, 0, 32'hD0, 0, 0);
    a_wb(2, 1, 32'hD1, 0, 0);
    cyc();
    #1;
    chk("t1_cv_pair", a_cv, 2'b11);
    chk("t1_cidx_pair", a_cidx, {5'd1, 5'd0});
    chk("t1_crd_pair", a_crd, {5'd2, 5'd1});
    chk("t1_cdata_pair", a_cdata, {32'hD1, 32'hD0});
    chk("t1_cwe_pair", a_cwe, 2'b11);
    cyc();
    #1;
    chk("t1_cv_last", a_cv, 2'b01);
    chk("t1_cidx_last", a_cidx[4:0], 2);
    chk("t1_crd_last", a_crd[4:0], 3);
    chk("t1_cdata_last", a_cdata[31:0], 32'hD2);
    cyc();
    #1;
    chk("t1_empty", a_empty, 1);

    // Same-index writeback collision: port 3 beats port 0
    for (int i = 0; i < 3; i++) begin
      a_disp(10 + i);
      #1;
      chk("t2_didx", a_didx, 5'(3 + i));
      cyc();
    end
    a_wb(1, 3, 32'h33, 0, 0);
    a_wb(2, 4, 32'h44, 0, 0);
    a_wb(0, 5, 32'hAAAA, 0, 0);
    a_wb(3, 5, 32'h5555, 0, 0);
    cyc();
    #1;
    chk("t2_cv_pair", a_cv, 2'b11);
    chk("t2_cdata_pair", a_cdata, {32'h44, 32'h33});
    cyc();
    #1;
    chk("t2_cidx5", a_cidx[4:0], 5);
    chk("t2_collision_data", a_cdata[31:0], 32'h5555);
    cyc();

    // Branch redirect at slot 0 suppresses slot 1 and flushes
    a_disp(20);
    #1;
    chk("t3_didx6", a_didx, 6);
    cyc();
    a_disp(21);
    cyc();
    a_wb(0, 6, 32'h66, 1, 32'h6000_0080);
    a_wb(1, 7, 32'h77, 0, 0);
    cyc();
    a_disp(22);
    a_wb(2, 8, 32'h88, 0, 0);
    #1;
    chk("t3_cv", a_cv, 2'b01);
    chk("t3_flush", a_flush, 1);
    chk("t3_fpc", a_fpc, 32'h6000_0080);
    chk("t3_ready_flush", a_dr, 0);
    cyc();
    #1;
    chk("t3_empty", a_empty, 1);
    chk("t3_count", a_cnt, 0);
    chk("t3_didx0", a_didx, 0);
    chk("t3_flush_clr", a_flush, 0);
    chk("t3_cv_clr", a_cv, 0);

    // Fill to DEPTH, then retire one
    for (int i = 0; i < 32; i++) begin
      a_disp(i);
      cyc();
    end
    #1;
    chk("t4_count_full", a_cnt, 32);
    chk("t4_ready_full", a_dr, 0);
    a_disp(31);
    cyc();
    #1;
    chk("t4_count_held", a_cnt, 32);
    a_wb(0, 0, 32'hF0, 0, 0);
    cyc();
    a_disp(30);
    #1;
    chk("t4_cv", a_cv, 2'b01);
    chk("t4_ready_same_cycle", a_dr, 0);
    cyc();
    #1;
    chk("t4_count_after", a_cnt, 31);
    chk("t4_ready_after", a_dr, 1);
    chk("t4_didx_wrap", a_didx, 0);

    rst = 1'b0;
    #1;
    chk("t4_rst_count", a_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset with live entries
    for (int i = 0; i < 5; i++) begin
      a_disp(i);
      #1;
      chk("t5_didx", a_didx, 5'(i));
      cyc();
    end
    a_wb(0, 0, 32'hE0, 0, 0);
    cyc();
    #1;
    chk("t5_cv_pre", a_cv, 2'b01);
    chk("t5_count_pre", a_cnt, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_count", a_cnt, 0);
    chk("t5_empty", a_empty, 1);
    chk("t5_ready", a_dr, 1);
    chk("t5_cv", a_cv, 0);
    chk("t5_flush", a_flush, 0);
    chk("t5_fpc", a_fpc, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    #1;
    chk("t5_cv_post", a_cv, 0);
    chk("t5_count_post", a_cnt, 0);
    a_disp(9);
    #1;
    chk("t5_didx_post", a_didx, 0);
    cyc();
    #1;
    chk("t5_count_one", a_cnt, 1);

    // Streamed traffic on the small instance with a scoreboard
    ndisp = 0; ncomm = 0; tail_m = 0;
    for (int c = 0; c < 160; c++) begin
      b_idle();
      dv = (c < 100) && ($urandom_range(0, 3) != 0);
      b_dv = dv;
      b_drd = 5'(ndisp);
      b_dwe = 1'b1;
      b_dpc = 32'(ndisp * 4);
      wbd = 0;
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_pick = $urandom_range(0, pend.size() - 1);
        wb_idx_v = pend[wb_pick];
        pend.delete(wb_pick);
        wb_port = $urandom_range(0, 3);
        exp_data[wb_idx_v] = 32'hC000_0000 + 32'(c);
        b_wbv[wb_port] = 1'b1;
        b_wbidx[wb_port*3 +: 3] = 3'(wb_idx_v);
        b_wbdata[wb_port*32 +: 32] = exp_data[wb_idx_v];
        wbd = 1;
      end
      #1;
      qs = sbq.size();
      chk("s_ready", b_dr, (qs < 8) ? 1 : 0);
      chk("s_count", b_cnt, qs);
      hs = dv && (qs < 8);
      if (hs) chk("s_didx", b_didx, tail_m % 8);
      ncom_exp = 0;
      while (ncom_exp < 4 && ncom_exp < qs && sbq[ncom_exp].done) ncom_exp++;
      cmask = 4'((1 << ncom_exp) - 1);
      chk("s_cv", b_cv, cmask);
      for (int k = 0; k < ncom_exp; k++) begin
        chk("s_cidx", b_cidx[k*3 +: 3], sbq[0].idx);
        chk("s_crd", b_crd[k*5 +: 5], sbq[0].rd);
        chk("s_cdata", b_cdata[k*32 +: 32], exp_data[sbq[0].idx]);
        void'(sbq.pop_front());
        ncomm++;
      end
      @(posedge clk);
      if (hs) begin
        sbq.push_back('{tail_m % 8, ndisp % 32, 1'b0});
        pend.push_back(tail_m % 8);
        tail_m++;
        ndisp++;
      end
      if (wbd) begin
        foreach (sbq[j]) if (sbq[j].idx == wb_idx_v) sbq[j].done = 1'b1;
      end
      @(negedge clk);
    end
    b_idle();
    #1;
    chk("s_all_retired", ncomm, ndisp);
    chk("s_final_empty", b_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 32, ROB entry count; power of two, 4..64.
REQ-002 SHALL have parameter NUM_WB, default 4, writeback ports (alu, mul, br, mem).
REQ-003 SHALL have parameter COMMIT_W, default 2, max in-order commits per cycle; 1..4.
REQ-004 SHALL define localparam IDX_W = clog2(DEPTH).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 dispatch_valid  in  1  allocate request.
REQ-008 dispatch_ready  out  1  entry free and no flush this cycle.
REQ-009 dispatch_rd_addr  in  5;  dispatch_regf_we  in  1;  dispatch_pc  in  32  entry payload.
REQ-010 dispatch_idx  out  IDX_W  index allocated on handshake (current tail).
REQ-011 wb_valid  in  NUM_WB;  wb_idx  in  NUM_WB*IDX_W;  wb_data  in  NUM_WB*32  completion ports.
REQ-012 wb_br_en  in  NUM_WB;  wb_pc_new  in  NUM_WB*32  redirect flag and target.
REQ-013 commit_valid  out  COMMIT_W;  commit_idx  out  COMMIT_W*IDX_W  per-slot retire.
REQ-014 commit_rd_addr  out  COMMIT_W*5;  commit_data  out  COMMIT_W*32;  commit_regf_we  out  COMMIT_W  retire payload; slot 0 oldest.
REQ-015 flush  out  1;  flush_pc  out  32  redirect from a retiring br_en entry.
REQ-016 count  out  IDX_W+1;  empty  out  1  occupancy.

Function
REQ-017 Storage SHALL be circular; head/tail pointers IDX_W+1 bits, MSB wrap bit; full = idx equal and wrap differ.
REQ-018 Entry status SHALL use status_t: empty -> rob_wait on dispatch, rob_wait -> done on writeback, -> empty on commit/flush.
REQ-019 dispatch_ready SHALL be combinational: !full && !flush, full from registered pointers only (same-cycle commit does not free a slot).
REQ-020 Dispatch handshake SHALL write the entry at tail and advance tail by 1 at that edge.
REQ-021 Writeback SHALL mark entry done, store data, br_en, pc_new at the edge; writes to non-rob_wait entries ignored.
REQ-022 Two ports writing the same idx in one cycle: higher port number SHALL win.
REQ-023 commit_valid[k] SHALL be combinational: entries head..head+k all done, k < count, and no slot j<k has br_en=1.
REQ-024 Latency: dispatch edge N, writeback edge N+1, commit_valid high during cycle N+1 to N+2 at earliest; head advances by popcount(commit_valid) at the edge.
REQ-025 A committing entry with br_en=1 SHALL assert flush with flush_pc = its pc_new in the same cycle; later slots suppressed.
REQ-026 Flush edge SHALL clear every entry to empty, set head = tail = 0 and ignore all writebacks and dispatch that cycle.
REQ-027 count SHALL equal tail - head (IDX_W+1 bits), DEPTH when full; empty = (count == 0).
REQ-028 Pointer wrap SHALL be natural modulo 2*DEPTH; no reset on wrap.

Reset
REQ-029 On rst low, immediately: all entries empty, head = tail = 0, count 0, empty 1, dispatch_ready 1, commit_valid 0, flush 0, flush_pc 0.
REQ-030 Reset mid-operation SHALL discard all in-flight entries; first post-reset dispatch gets idx 0.

Structure
REQ-031 rv32i_types SHALL gain localparams ROB_DEPTH=32, ROB_NUM_WB=4, ROB_COMMIT_W=2 and struct rob_lite_entry_t {status_t, rd_addr, regf_we, pc, rd_data, br_en, pc_new}.
REQ-032 Commit eligibility (prefix-AND plus branch cut) SHALL be a combinational sub-module rob_commit_select, parametrised by COMMIT_W.

Verification
REQ-033 Reset, dispatch 3 (rd 1,2,3), writeback idx 2,0,1 out of order -> commit idx0,idx1 one cycle, idx2 next; data match.
REQ-034 Dispatch DEPTH entries, no writeback -> dispatch_ready 0, count 32; extra dispatch_valid ignored; one commit does not raise ready until next cycle.
REQ-035 Ports 0 and 3 write idx 5 same cycle (data 0xAAAA, 0x5555) -> commit_data 0x5555.
REQ-036 Slot 0 br_en=1 pc_new 0x60000080, slot 1 done -> only slot 0 commits, flush=1, flush_pc 0x60000080, next cycle empty=1, dispatch_idx 0.
REQ-037 Stream 100 dispatch/writeback/commit cycles with DEPTH=8, COMMIT_W=4 -> wrap correct, retire order equals dispatch order.
REQ-038 Drop rst while 5 entries live -> outputs at reset values before next clk edge; no commits afterwards.
